// File: rtl/iob_fp_div_pkg.sv
// Shared constants and FSM encoding for the iterative single-precision divider.
// The widths and constants describe the default IEEE-754 binary32 format.
package iob_fp_div_pkg;

  localparam int unsigned FP_DATA_W = 32;
  localparam int unsigned FP_EXP_W  = 8;
  localparam int unsigned MAN_W     = FP_DATA_W - FP_EXP_W - 1;
  localparam int unsigned DIV_ITERS = MAN_W + 3;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned BIAS      = 127;
  localparam int unsigned EXP_MAX   = 255;
  localparam logic [31:0] QNAN      = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    StIdle,
    StUnpack,
    StDiv,
    StNorm,
    StRound
  } div_state_e;

endpackage

// File: rtl/iob_fp_div_if.sv
// Start/done core handshake shared by the floating-point cores.
interface iob_fp_div_if #(
  parameter int unsigned DATA_W = 32
);
  logic              start_i;
  logic [DATA_W-1:0] op_a_i;
  logic [DATA_W-1:0] op_b_i;
  logic [DATA_W-1:0] res_o;
  logic              done_o;
  logic              overflow_o;
  logic              underflow_o;
  logic              exception_o;

  modport master (
    output start_i, op_a_i, op_b_i,
    input  res_o, done_o, overflow_o, underflow_o, exception_o
  );

  modport slave (
    input  start_i, op_a_i, op_b_i,
    output res_o, done_o, overflow_o, underflow_o, exception_o
  );
endinterface

// File: rtl/iob_fp_classify.sv
// Combinational operand classifier; takes the magnitude only (sign is not needed).
module iob_fp_classify #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned EXP_W  = 8
) (
  input  logic [DATA_W-2:0] mag_i,
  output logic              zero_o,
  output logic              inf_o,
  output logic              nan_o,
  output logic              subnormal_o
);
  localparam int unsigned ManW = DATA_W - EXP_W - 1;

  logic [EXP_W-1:0] exp;
  logic [ManW-1:0]  man;
  logic             exp_zero;
  logic             exp_ones;
  logic             man_zero;

  assign exp      = mag_i[DATA_W-2 -: EXP_W];
  assign man      = mag_i[ManW-1:0];
  assign exp_zero = (exp == '0);
  assign exp_ones = (exp == '1);
  assign man_zero = (man == '0);

  assign zero_o      = exp_zero & man_zero;
  assign subnormal_o = exp_zero & ~man_zero;
  assign inf_o       = exp_ones & man_zero;
  assign nan_o       = exp_ones & ~man_zero;
endmodule

// File: rtl/iob_fp_div.sv
// Fixed-latency restoring IEEE-754 divider with round-to-nearest-even.
// Specials traverse every state so done_o always lands the same number of cycles after start.
module iob_fp_div
  import iob_fp_div_pkg::*;
#(
  parameter int unsigned DATA_W = FP_DATA_W,
  parameter int unsigned EXP_W  = FP_EXP_W
) (
  input logic         clk,
  input logic         rst,
  iob_fp_div_if.slave bus
);
  localparam int unsigned ManW     = DATA_W - EXP_W - 1;
  localparam int unsigned ExpSW    = EXP_W + 2;
  localparam int unsigned DivIters = ManW + 3;
  localparam logic signed [ExpSW-1:0] BiasS   = ExpSW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [ExpSW-1:0] ExpMaxS = ExpSW'((1 << EXP_W) - 1);
  localparam logic signed [ExpSW-1:0] OneS    = ExpSW'(1);
  localparam logic signed [ExpSW-1:0] ZeroS   = '0;
  localparam logic [CNT_W-1:0]        LastCnt = CNT_W'(DivIters - 1);
  localparam logic [DATA_W-1:0]       QNaN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(ManW-1){1'b0}}};

  div_state_e state_q, state_d;
  logic load_en, unpack_en, div_en, norm_en, round_en;

  logic [DATA_W-1:0]       op_a_q, op_b_q;
  logic                    sign_q;
  logic signed [ExpSW-1:0] exp_q;
  logic [ManW:0]           mb_q, mant_q;
  logic [ManW+1:0]         rem_q;
  logic [ManW+2:0]         quo_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    guard_q, round_q, sticky_q;
  logic                    special_q, special_exc_q;
  logic [DATA_W-1:0]       special_res_q;
  logic [DATA_W-1:0]       res_q;
  logic                    done_q, ovf_q, unf_q, exc_q;

  logic a_zero, a_inf, a_nan, a_sub;
  logic b_zero, b_inf, b_nan, b_sub;

  iob_fp_classify #(.DATA_W(DATA_W), .EXP_W(EXP_W)) u_class_a (
    .mag_i       (op_a_q[DATA_W-2:0]),
    .zero_o      (a_zero),
    .inf_o       (a_inf),
    .nan_o       (a_nan),
    .subnormal_o (a_sub)
  );

  iob_fp_classify #(.DATA_W(DATA_W), .EXP_W(EXP_W)) u_class_b (
    .mag_i       (op_b_q[DATA_W-2:0]),
    .zero_o      (b_zero),
    .inf_o       (b_inf),
    .nan_o       (b_nan),
    .subnormal_o (b_sub)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus.start_i) state_d = StUnpack;
      StUnpack: state_d = StDiv;
      StDiv:    if (cnt_q == LastCnt) state_d = StNorm;
      StNorm:   state_d = StRound;
      StRound:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    load_en   = 1'b0;
    unpack_en = 1'b0;
    div_en    = 1'b0;
    norm_en   = 1'b0;
    round_en  = 1'b0;
    unique case (state_q)
      StIdle:   load_en   = bus.start_i;
      StUnpack: unpack_en = 1'b1;
      StDiv:    div_en    = 1'b1;
      StNorm:   norm_en   = 1'b1;
      StRound:  round_en  = 1'b1;
      default:  ;
    endcase
  end

  // Unpack: subnormals count as zero; specials are resolved here and carried to ROUND.
  logic                    sign_u, a_z, b_z;
  logic signed [ExpSW-1:0] exp_u;
  logic                    spec_d, spec_exc_d;
  logic [DATA_W-1:0]       spec_res_d;

  assign sign_u = op_a_q[DATA_W-1] ^ op_b_q[DATA_W-1];
  assign a_z    = a_zero | a_sub;
  assign b_z    = b_zero | b_sub;
  assign exp_u  = $signed({2'b00, op_a_q[DATA_W-2 -: EXP_W]})
                - $signed({2'b00, op_b_q[DATA_W-2 -: EXP_W]}) + BiasS;

  always_comb begin
    spec_d     = 1'b1;
    spec_exc_d = 1'b0;
    spec_res_d = '0;
    if (a_nan || b_nan || (a_z && b_z) || (a_inf && b_inf)) begin
      spec_res_d = QNaN;
      spec_exc_d = 1'b1;
    end else if (a_inf) begin
      spec_res_d = {sign_u, {EXP_W{1'b1}}, {ManW{1'b0}}};
    end else if (b_z) begin
      spec_res_d = {sign_u, {EXP_W{1'b1}}, {ManW{1'b0}}};
      spec_exc_d = 1'b1;
    end else if (a_z || b_inf) begin
      spec_res_d = {sign_u, {(DATA_W-1){1'b0}}};
    end else begin
      spec_d = 1'b0;
    end
  end

  // One restoring step; the remainder stays below the divisor so the shift loses nothing.
  logic [ManW+1:0] mb_ext, rem_sel, rem_shift;
  logic            q_bit;

  assign mb_ext    = {1'b0, mb_q};
  assign q_bit     = (rem_q >= mb_ext);
  assign rem_sel   = q_bit ? (rem_q - mb_ext) : rem_q;
  assign rem_shift = rem_sel << 1;

  logic                    inc, carry;
  logic [ManW+1:0]         mant_sum;
  logic [ManW-1:0]         frac;
  logic signed [ExpSW-1:0] exp_r;
  logic [DATA_W-1:0]       res_d;
  logic                    ovf_d, unf_d, exc_d;

  assign inc      = guard_q & (round_q | sticky_q | mant_q[0]);
  assign mant_sum = {1'b0, mant_q} + {{(ManW+1){1'b0}}, inc};
  assign carry    = mant_sum[ManW+1];
  assign frac     = carry ? mant_sum[ManW:1] : mant_sum[ManW-1:0];
  assign exp_r    = carry ? (exp_q + OneS) : exp_q;

  always_comb begin
    res_d = {sign_q, exp_r[EXP_W-1:0], frac};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    exc_d = 1'b0;
    if (special_q) begin
      res_d = special_res_q;
      exc_d = special_exc_q;
    end else if (exp_r >= ExpMaxS) begin
      res_d = {sign_q, {EXP_W{1'b1}}, {ManW{1'b0}}};
      ovf_d = 1'b1;
    end else if (exp_r <= ZeroS) begin
      res_d = {sign_q, {(DATA_W-1){1'b0}}};
      unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_q        <= '0;
      op_b_q        <= '0;
      sign_q        <= 1'b0;
      exp_q         <= ZeroS;
      mb_q          <= '0;
      mant_q        <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      cnt_q         <= '0;
      guard_q       <= 1'b0;
      round_q       <= 1'b0;
      sticky_q      <= 1'b0;
      special_q     <= 1'b0;
      special_exc_q <= 1'b0;
      special_res_q <= '0;
      res_q         <= '0;
      done_q        <= 1'b0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
      exc_q         <= 1'b0;
    end else begin
      if (load_en) begin
        op_a_q <= bus.op_a_i;
        op_b_q <= bus.op_b_i;
      end
      if (unpack_en) begin
        sign_q        <= sign_u;
        exp_q         <= exp_u;
        mb_q          <= {1'b1, op_b_q[ManW-1:0]};
        rem_q         <= {2'b01, op_a_q[ManW-1:0]};
        quo_q         <= '0;
        cnt_q         <= '0;
        special_q     <= spec_d;
        special_exc_q <= spec_exc_d;
        special_res_q <= spec_res_d;
      end
      if (div_en) begin
        rem_q <= rem_shift;
        quo_q <= {quo_q[ManW+1:0], q_bit};
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (norm_en) begin
        sticky_q <= |rem_q;
        if (quo_q[ManW+2]) begin
          mant_q  <= quo_q[ManW+2:2];
          guard_q <= quo_q[1];
          round_q <= quo_q[0];
        end else begin
          mant_q  <= quo_q[ManW+1:1];
          guard_q <= quo_q[0];
          round_q <= 1'b0;
          exp_q   <= exp_q - OneS;
        end
      end
      if (round_en) begin
        res_q <= res_d;
        ovf_q <= ovf_d;
        unf_q <= unf_d;
        exc_q <= exc_d;
      end
      done_q <= round_en;
    end
  end

  assign bus.res_o       = res_q;
  assign bus.done_o      = done_q;
  assign bus.overflow_o  = ovf_q;
  assign bus.underflow_o = unf_q;
  assign bus.exception_o = exc_q;
endmodule

// File: tb/tb_iob_fp_div.sv
// Scoreboard bench for iob_fp_div: expected results are queued at launch and
// compared, together with the fixed latency, when done_o pulses.
module tb_iob_fp_div;
  import iob_fp_div_pkg::*;

  localparam int Latency = 29;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iob_fp_div_if #(.DATA_W(32)) bus ();

  iob_fp_div #(.DATA_W(32), .EXP_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    logic        exc;
    int          launch;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic prev_done = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.done_o === 1'b1) begin
      check_eq("done_single_cycle", 32'(prev_done), 32'd0);
      if (sb.size() == 0) begin
        check_eq("unexpected_done", 32'(bus.done_o), 32'd0);
      end else begin
        cur = sb.pop_front();
        check_eq({cur.name, "_res"}, bus.res_o, cur.res);
        check_eq({cur.name, "_ovf"}, 32'(bus.overflow_o), 32'(cur.ovf));
        check_eq({cur.name, "_unf"}, 32'(bus.underflow_o), 32'(cur.unf));
        check_eq({cur.name, "_exc"}, 32'(bus.exception_o), 32'(cur.exc));
        check_eq({cur.name, "_lat"}, 32'(cyc - cur.launch), 32'(Latency));
      end
    end
    prev_done = bus.done_o;
  end

  task automatic push_exp(input string name, input logic [31:0] res, input logic ovf,
                          input logic unf, input logic exc, input int launch);
    exp_t e;
    e.name   = name;
    e.res    = res;
    e.ovf    = ovf;
    e.unf    = unf;
    e.exc    = exc;
    e.launch = launch;
    sb.push_back(e);
  endtask

  // Drives a one-cycle start pulse; the next posedge (cyc + 1) is the launch edge.
  task automatic launch(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic ovf, input logic unf,
                        input logic exc);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_a_i  = a;
    bus.op_b_i  = b;
    push_exp(name, res, ovf, unf, exc, cyc + 1);
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic ovf, input logic unf,
                        input logic exc);
    launch(name, a, b, res, ovf, unf, exc);
    wait_idle(60);
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.op_a_i  = '0;
    bus.op_b_i  = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_res", bus.res_o, 32'h0);
    check_eq("rst_done", 32'(bus.done_o), 32'd0);
    check_eq("rst_flags", 32'({bus.overflow_o, bus.underflow_o, bus.exception_o}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("six_div_two", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0, 1'b0);
    run_op("one_third",   32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 1'b0, 1'b0, 1'b0);
    run_op("neg_half",    32'hBF80_0000, 32'h4000_0000, 32'hBF00_0000, 1'b0, 1'b0, 1'b0);
    run_op("one_seventh", 32'h3F80_0000, 32'h40E0_0000, 32'h3E12_4925, 1'b0, 1'b0, 1'b0);
    run_op("two_thirds",  32'h4000_0000, 32'h4040_0000, 32'h3F2A_AAAB, 1'b0, 1'b0, 1'b0);
    run_op("neg_neg",     32'hC080_0000, 32'hC000_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0);
    run_op("one_one",     32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, 1'b0);
    run_op("div_zero",    32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b0, 1'b0, 1'b1);
    run_op("neg_div_zero", 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b0, 1'b0, 1'b1);
    run_op("div_subnorm", 32'h3F80_0000, 32'h0000_0001, 32'h7F80_0000, 1'b0, 1'b0, 1'b1);
    run_op("zero_zero",   32'h0000_0000, 32'h0000_0000, QNAN, 1'b0, 1'b0, 1'b1);
    run_op("inf_inf",     32'h7F80_0000, 32'h7F80_0000, QNAN, 1'b0, 1'b0, 1'b1);
    run_op("nan_in",      32'h7FC0_0001, 32'h3F80_0000, QNAN, 1'b0, 1'b0, 1'b1);
    run_op("zero_num",    32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    run_op("negz_num",    32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    run_op("subnorm_num", 32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    run_op("inf_num",     32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0, 1'b0, 1'b0);
    run_op("num_neg_inf", 32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    run_op("overflow",    32'h7F7F_FFFF, 32'h3E80_0000, 32'h7F80_0000, 1'b1, 1'b0, 1'b0);
    run_op("underflow",   32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0);

    // Start pulses while busy must be ignored.
    launch("busy", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_a_i  = 32'h3F80_0000;
    bus.op_b_i  = 32'h4040_0000;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (12) @(negedge clk);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_idle(60);
    repeat (40) @(negedge clk);

    // start_i held high relaunches every 30 cycles.
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_a_i  = 32'h4120_0000;
    bus.op_b_i  = 32'h40A0_0000;
    push_exp("held0", 32'h4000_0000, 1'b0, 1'b0, 1'b0, cyc + 1);
    push_exp("held1", 32'h4000_0000, 1'b0, 1'b0, 1'b0, cyc + 31);
    push_exp("held2", 32'h4000_0000, 1'b0, 1'b0, 1'b0, cyc + 61);
    repeat (65) @(negedge clk);
    bus.start_i = 1'b0;
    wait_idle(100);

    // Reset mid-operation aborts without a done pulse.
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_a_i  = 32'h40C0_0000;
    bus.op_b_i  = 32'h4000_0000;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_res", bus.res_o, 32'h0);
    check_eq("midrst_done", 32'(bus.done_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("postrst_res", bus.res_o, 32'h0);
    check_eq("postrst_flags", 32'({bus.overflow_o, bus.underflow_o, bus.exception_o}), 32'd0);
    run_op("after_rst", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
